// File: rtl/decode_stage_if.sv
// Fetch-to-execute handshake bundle for decode_stage: raw instruction in,
// decoded control/immediate fields out, each side on valid/ready.
interface decode_stage_if #(parameter int XLEN = 32);
   logic            in_valid;
   logic            in_ready;
   logic [31:0]     in_inst;
   logic            out_valid;
   logic            out_ready;
   logic [3:0]      out_alu_op;
   logic            out_use_imm;
   logic [XLEN-1:0] out_imm;
   logic [4:0]      out_rs1;
   logic [4:0]      out_rs2;
   logic [4:0]      out_rd;
   logic            out_rd_we;
   logic            out_branch;
   logic [2:0]      out_br_cond;
   logic            out_illegal;

   modport master (
      output in_valid, in_inst, out_ready,
      input  in_ready, out_valid, out_alu_op, out_use_imm, out_imm,
             out_rs1, out_rs2, out_rd, out_rd_we, out_branch, out_br_cond, out_illegal
   );

   modport slave (
      input  in_valid, in_inst, out_ready,
      output in_ready, out_valid, out_alu_op, out_use_imm, out_imm,
             out_rs1, out_rs2, out_rd, out_rd_we, out_branch, out_br_cond, out_illegal
   );
endinterface

// File: rtl/decode_stage.sv
// Registered RV decode for OP/OP-IMM/BRANCH/LUI with an output register plus
// one skid entry, so in_ready depends only on local state.
module decode_stage #(
   parameter int XLEN     = 32,
   parameter bit FULL_ALU = 1'b1
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          flush,
   decode_stage_if.slave bus
);

   localparam logic [4:0] OPC_OP     = 5'b01100;
   localparam logic [4:0] OPC_OPIMM  = 5'b00100;
   localparam logic [4:0] OPC_BRANCH = 5'b11000;
   localparam logic [4:0] OPC_LUI    = 5'b01101;
   localparam logic [6:0] F7_ALT     = 7'b0100000;

   typedef enum logic [3:0] {
      ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
      ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
      ALU_OR = 4'd8, ALU_AND = 4'd9, ALU_PASSIMM = 4'd10
   } alu_e;

   typedef struct packed {
      logic [3:0]      alu_op;
      logic            use_imm;
      logic [XLEN-1:0] imm;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic            rd_we;
      logic            branch;
      logic [2:0]      br_cond;
      logic            illegal;
   } dec_t;

   // ALU op for the funct3 codes that only exist in the full ALU set
   function automatic logic [3:0] full_op(input logic [2:0] f3);
      case (f3)
         3'b010:  full_op = ALU_SLT;
         3'b011:  full_op = ALU_SLTU;
         3'b100:  full_op = ALU_XOR;
         3'b110:  full_op = ALU_OR;
         default: full_op = ALU_AND;
      endcase
   endfunction

   logic [31:0]     inst;
   logic [4:0]      opc;
   logic [2:0]      f3;
   logic [6:0]      f7;
   logic [XLEN-1:0] imm_i, imm_b, imm_u, imm_sh;
   logic            sh_hi_bad;

   assign inst      = bus.in_inst;
   assign opc       = inst[6:2];
   assign f3        = inst[14:12];
   assign f7        = inst[31:25];
   assign imm_i     = {{(XLEN-11){inst[31]}}, inst[30:20]};
   assign imm_b     = {{(XLEN-12){inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
   assign imm_u     = {{(XLEN-31){inst[31]}}, inst[30:12], 12'h000};
   assign imm_sh    = {{(XLEN-6){1'b0}}, (XLEN == 64) ? inst[25] : 1'b0, inst[24:20]};
   // shamt bit 5 only exists on RV64
   assign sh_hi_bad = (XLEN == 32) && inst[25];

   dec_t dec;
   logic ill;

   always_comb begin
      dec         = '0;
      ill         = 1'b0;
      dec.rs1     = inst[19:15];
      dec.rs2     = inst[24:20];
      dec.rd      = inst[11:7];
      dec.br_cond = f3;
      case (opc)
         OPC_OP: begin
            dec.rd_we = 1'b1;
            case (f3)
               3'b000: begin
                  if (f7 == 7'h00)        dec.alu_op = ALU_ADD;
                  else if (f7 == F7_ALT)  dec.alu_op = ALU_SUB;
                  else                    ill = 1'b1;
               end
               3'b001: begin
                  dec.alu_op = ALU_SLL;
                  ill        = (f7 != 7'h00);
               end
               3'b101: begin
                  if (f7 == 7'h00)        dec.alu_op = ALU_SRL;
                  else if (f7 == F7_ALT)  dec.alu_op = ALU_SRA;
                  else                    ill = 1'b1;
               end
               default: begin
                  dec.alu_op = full_op(f3);
                  ill        = (f7 != 7'h00) || !FULL_ALU;
               end
            endcase
         end
         OPC_OPIMM: begin
            dec.rd_we   = 1'b1;
            dec.use_imm = 1'b1;
            dec.imm     = imm_i;
            case (f3)
               3'b000: dec.alu_op = ALU_ADD;
               3'b001: begin
                  dec.alu_op = ALU_SLL;
                  dec.imm    = imm_sh;
                  ill        = (inst[31:26] != 6'b000000) || sh_hi_bad;
               end
               3'b101: begin
                  dec.imm = imm_sh;
                  if (inst[31:26] == 6'b000000)       dec.alu_op = ALU_SRL;
                  else if (inst[31:26] == 6'b010000)  dec.alu_op = ALU_SRA;
                  else                                ill = 1'b1;
                  if (sh_hi_bad) ill = 1'b1;
               end
               default: begin
                  dec.alu_op = full_op(f3);
                  ill        = !FULL_ALU;
               end
            endcase
         end
         OPC_BRANCH: begin
            dec.alu_op = ALU_SUB;
            dec.branch = 1'b1;
            dec.imm    = imm_b;
            ill        = (f3[2:1] == 2'b01) || (f3[2] && !FULL_ALU);
         end
         OPC_LUI: begin
            dec.alu_op  = ALU_PASSIMM;
            dec.use_imm = 1'b1;
            dec.rd_we   = 1'b1;
            dec.imm     = imm_u;
         end
         default: ill = 1'b1;
      endcase
      if (inst[1:0] != 2'b11) ill = 1'b1;
      if (ill) begin
         dec.rd_we  = 1'b0;
         dec.branch = 1'b0;
      end
      dec.illegal = ill;
   end

   dec_t out_q, skid_q;
   logic out_v, skid_v;
   logic accept, drain;

   assign accept = bus.in_valid && !skid_v && !flush;
   assign drain  = out_v && bus.out_ready;

   // skid only fills while the output register is held, so skid_v implies out_v
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_v  <= 1'b0;
         skid_v <= 1'b0;
         out_q  <= '0;
         skid_q <= '0;
      end else if (flush) begin
         out_v  <= 1'b0;
         skid_v <= 1'b0;
      end else if (!out_v || drain) begin
         if (skid_v) begin
            out_q  <= skid_q;
            out_v  <= 1'b1;
            skid_v <= 1'b0;
         end else begin
            out_v <= accept;
            if (accept) out_q <= dec;
         end
      end else if (accept) begin
         skid_q <= dec;
         skid_v <= 1'b1;
      end
   end

   assign bus.in_ready    = !skid_v;
   assign bus.out_valid   = out_v;
   assign bus.out_alu_op  = out_q.alu_op;
   assign bus.out_use_imm = out_q.use_imm;
   assign bus.out_imm     = out_q.imm;
   assign bus.out_rs1     = out_q.rs1;
   assign bus.out_rs2     = out_q.rs2;
   assign bus.out_rd      = out_q.rd;
   assign bus.out_rd_we   = out_q.rd_we;
   assign bus.out_branch  = out_q.branch;
   assign bus.out_br_cond = out_q.br_cond;
   assign bus.out_illegal = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Drives an RV64/full-ALU and an RV32/reduced-ALU decode_stage in lockstep and
// checks both against a FIFO-of-instructions reference model.
module tb_decode_stage;
   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        flush = 1'b0;
   logic        v = 1'b0;
   logic        rdy = 1'b0;
   logic [31:0] inst = 32'h0;
   int          n_chk = 0;
   int          n_err = 0;
   logic [31:0] q[$];

   localparam logic [31:0] OPTBL = {4'd9, 4'd8, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd0};

   typedef struct packed {
      logic [3:0]  alu;
      logic        ui;
      logic [63:0] imm;
      logic        we;
      logic        br;
      logic        ill;
      logic [2:0]  cond;
      logic        c1, c2, cd;
   } exp_t;

   decode_stage_if #(.XLEN(64)) b64();
   decode_stage_if #(.XLEN(32)) b32();

   assign b64.in_valid = v;
   assign b64.in_inst = inst;
   assign b64.out_ready = rdy;
   assign b32.in_valid = v;
   assign b32.in_inst = inst;
   assign b32.out_ready = rdy;

   always #5 clk = ~clk;

   decode_stage #(.XLEN(64), .FULL_ALU(1'b1)) u64 (.clk(clk), .reset_n(reset_n), .flush(flush), .bus(b64));
   decode_stage #(.XLEN(32), .FULL_ALU(1'b0)) u32 (.clk(clk), .reset_n(reset_n), .flush(flush), .bus(b32));

   function automatic exp_t ref_dec(logic [31:0] i, bit x64, bit full);
      exp_t e;
      logic [2:0] f3;
      logic [6:0] f7;
      logic [5:0] top6;
      bit legal;
      e = '0;
      f3 = i[14:12];
      f7 = i[31:25];
      top6 = i[31:26];
      legal = 1'b1;
      case (i[6:2])
         5'b01100: begin
            e.we = 1; e.c1 = 1; e.c2 = 1; e.cd = 1;
            if (f7 == 7'h00) begin
               e.alu = OPTBL[f3*4 +: 4];
               legal = (f3 == 0 || f3 == 1 || f3 == 5) || full;
            end else if (f7 == 7'h20 && (f3 == 0 || f3 == 5)) begin
               e.alu = (f3 == 0) ? 4'd1 : 4'd7;
            end else legal = 0;
         end
         5'b00100: begin
            e.we = 1; e.ui = 1; e.c1 = 1; e.cd = 1;
            e.imm = {{52{i[31]}}, i[31:20]};
            if (f3 == 1 || f3 == 5) begin
               legal = (top6 == 0 || (top6 == 6'b010000 && f3 == 5)) && (x64 || !i[25]);
               e.alu = (f3 == 1) ? 4'd2 : ((top6 == 0) ? 4'd6 : 4'd7);
               e.imm = x64 ? {58'b0, i[25:20]} : {59'b0, i[24:20]};
            end else begin
               e.alu = OPTBL[f3*4 +: 4];
               legal = (f3 == 0) || full;
            end
         end
         5'b11000: begin
            e.br = 1; e.alu = 4'd1; e.cond = f3; e.c1 = 1; e.c2 = 1;
            e.imm = {{51{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            legal = (f3 < 2) || (f3 >= 4 && full);
         end
         5'b01101: begin
            e.alu = 4'd10; e.ui = 1; e.we = 1; e.cd = 1;
            e.imm = {{32{i[31]}}, i[31:12], 12'h000};
         end
         default: legal = 0;
      endcase
      if (i[1:0] != 2'b11) legal = 0;
      if (!x64) e.imm = {32'b0, e.imm[31:0]};
      if (!legal) begin
         e.ill = 1; e.we = 0; e.br = 0;
      end
      return e;
   endfunction

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic cmp(string p, exp_t e, logic [3:0] alu, logic ui, logic [63:0] imm,
                      logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd, logic we,
                      logic br, logic [2:0] cond, logic ill, logic [31:0] i);
      chk({p, "_ill"}, ill, e.ill);
      chk({p, "_we"}, we, e.we);
      chk({p, "_br"}, br, e.br);
      if (!e.ill) begin
         chk({p, "_alu"}, alu, e.alu);
         chk({p, "_ui"}, ui, e.ui);
         chk({p, "_imm"}, imm, e.imm);
         if (e.br) chk({p, "_cond"}, cond, e.cond);
         if (e.c1) chk({p, "_rs1"}, rs1, i[19:15]);
         if (e.c2) chk({p, "_rs2"}, rs2, i[24:20]);
         if (e.cd) chk({p, "_rd"}, rd, i[11:7]);
      end
   endtask

   task automatic check_all();
      chk("v64", b64.out_valid, q.size() > 0);
      chk("r64", b64.in_ready, q.size() < 2);
      chk("v32", b32.out_valid, q.size() > 0);
      chk("r32", b32.in_ready, q.size() < 2);
      if (q.size() > 0) begin
         cmp("d64", ref_dec(q[0], 1, 1), b64.out_alu_op, b64.out_use_imm, b64.out_imm,
             b64.out_rs1, b64.out_rs2, b64.out_rd, b64.out_rd_we, b64.out_branch,
             b64.out_br_cond, b64.out_illegal, q[0]);
         cmp("d32", ref_dec(q[0], 0, 0), b32.out_alu_op, b32.out_use_imm, 64'(b32.out_imm),
             b32.out_rs1, b32.out_rs2, b32.out_rd, b32.out_rd_we, b32.out_branch,
             b32.out_br_cond, b32.out_illegal, q[0]);
      end
   endtask

   task automatic chk_reset(string p);
      chk({p, "_v"}, {b64.out_valid, b32.out_valid}, 2'b00);
      chk({p, "_rdy"}, {b64.in_ready, b32.in_ready}, 2'b11);
      chk({p, "_alu"}, {b64.out_alu_op, b32.out_alu_op}, 8'h0);
      chk({p, "_imm64"}, b64.out_imm, 64'h0);
      chk({p, "_imm32"}, 64'(b32.out_imm), 64'h0);
      chk({p, "_regs"}, {b64.out_rs1, b64.out_rs2, b64.out_rd, b32.out_rs1, b32.out_rs2, b32.out_rd}, 30'h0);
      chk({p, "_flags"}, {b64.out_use_imm, b64.out_rd_we, b64.out_branch, b64.out_illegal, b64.out_br_cond,
                          b32.out_use_imm, b32.out_rd_we, b32.out_branch, b32.out_illegal, b32.out_br_cond}, 14'h0);
   endtask

   // returns whether the model predicts the presented instruction is accepted
   task automatic step(input bit sv, input logic [31:0] si, input bit sr, input bit sf, output bit acc);
      bit drn;
      v = sv; inst = si; rdy = sr; flush = sf;
      acc = sv && q.size() < 2 && !sf;
      drn = q.size() > 0 && sr;
      @(posedge clk);
      if (sf) q.delete();
      else begin
         if (drn) void'(q.pop_front());
         if (acc) q.push_back(si);
      end
      @(negedge clk);
      check_all();
   endtask

   function automatic logic [31:0] rnd_inst();
      logic [31:0] r;
      r = $urandom;
      case ($urandom_range(0, 9))
         0, 1: begin
            r[6:0] = 7'b0110011;
            case ($urandom_range(0, 3))
               0, 1: r[31:25] = 7'h00;
               2: r[31:25] = 7'h20;
               default: ;
            endcase
         end
         2, 3: begin
            r[6:0] = 7'b0010011;
            if ($urandom_range(0, 1) == 1) r[31:26] = ($urandom_range(0, 1) == 1) ? 6'b010000 : 6'b000000;
         end
         4, 5: r[6:0] = 7'b1100011;
         6, 7: r[6:0] = 7'b0110111;
         default: ;
      endcase
      return r;
   endfunction

   initial begin
      bit a;
      int idx;
      logic [31:0] stream[4];
      repeat (2) @(negedge clk);
      chk_reset("rst");
      reset_n = 1'b1;

      step(1, 32'h002081B3, 1, 0, a);   // ADD x3,x1,x2
      chk("add_alu", b64.out_alu_op, 4'd0);
      chk("add_rd", b64.out_rd, 5'd3);
      step(1, 32'hFFF00093, 1, 0, a);   // ADDI x1,x0,-1
      chk("addi_imm64", b64.out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
      step(1, 32'h800002B7, 1, 0, a);   // LUI x5,0x80000
      chk("lui_imm64", b64.out_imm, 64'hFFFF_FFFF_8000_0000);
      chk("lui_alu", b64.out_alu_op, 4'd10);
      step(1, 32'h0010C0B3, 1, 0, a);   // XOR x1,x1,x1
      chk("xor_alu64", b64.out_alu_op, 4'd5);
      chk("xor_ill32", {b32.out_illegal, b32.out_rd_we}, 2'b10);
      step(1, 32'h0020C463, 1, 0, a);   // BLT x1,x2,+8
      chk("blt_64", {b64.out_branch, b64.out_br_cond}, 4'b1100);
      chk("blt_imm64", b64.out_imm, 64'd8);
      chk("blt_ill32", {b32.out_illegal, b32.out_branch}, 2'b10);
      step(1, 32'h02009093, 1, 0, a);   // SLLI with inst[25]=1
      chk("slli_ill32", b32.out_illegal, 1'b1);
      chk("slli_imm64", b64.out_imm, 64'd32);
      chk("slli_alu64", {b64.out_illegal, b64.out_alu_op}, 5'd2);
      step(0, 32'h0, 1, 0, a);

      // four back-to-back, execute stalled for three cycles
      stream = '{32'h002081B3, 32'h40208133, 32'h00500293, 32'h00209463};
      idx = 0;
      for (int c = 0; c < 16; c++) begin
         step(idx < 4, stream[idx % 4], c >= 3, 0, a);
         if (a) idx++;
      end
      chk("stream_drained", {b64.out_valid, b32.out_valid}, 2'b00);

      // both entries full, then flush with a concurrent in_valid
      step(1, 32'h00100093, 0, 0, a);
      step(1, 32'h00200113, 0, 0, a);
      chk("full_rdy", b64.in_ready, 1'b0);
      step(1, 32'h00300193, 0, 1, a);
      chk("flush_state", {b64.out_valid, b64.in_ready, b32.out_valid, b32.in_ready}, 4'b0101);
      step(0, 32'h0, 1, 0, a);
      chk("flush_noacc", b64.out_valid, 1'b0);

      // asynchronous reset mid-stream
      step(1, 32'h0010C0B3, 0, 0, a);
      step(1, 32'h800002B7, 0, 0, a);
      #2 reset_n = 1'b0;
      #1 chk_reset("midrst");
      q.delete();
      @(negedge clk);
      reset_n = 1'b1;

      for (int c = 0; c < 800; c++)
         step($urandom_range(0, 3) != 0, rnd_inst(), $urandom_range(0, 2) != 0,
              $urandom_range(0, 40) == 0, a);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
